rs_integer: RTL and testbench

- Reservation station feeding the integer execution unit.
- Buffers dispatched integer ops until both operands are available, snooping the CDB for pending tags.
- Issues the oldest ready op per cycle as the packed 80-bit rs2exe word plus an enable, and consumes the 38-bit cdb word that execution broadcasts.
- Sits between rename/dispatch and the integer execution unit.

---
 rtl/core_pkg.sv | 37 +++
 rtl/rs_oldest_ready.sv | 22 ++
 rtl/rs_integer.sv | 131 +++++++++++++
 tb/tb_rs_integer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Types and constants shared by rename, the integer reservation station and the execution unit.
// Operand tag 0 means "value present"; CDB tag 0 means "no broadcast this cycle".
package core_pkg;

    localparam int TAG_W  = 6;
    localparam int XLEN   = 32;
    localparam int INST_W = 10;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag1;
        logic [XLEN-1:0]   val1;
        logic [TAG_W-1:0]  tag2;
        logic [XLEN-1:0]   val2;
    } rs_entry_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  dest;
        logic [XLEN-1:0]   opr1;
        logic [XLEN-1:0]   opr2;
    } rs2exe_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } cdb_t;

    // A pending operand picks up the broadcast value; tag 0 can never match.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag, input cdb_t bus);
        return (tag != TAG_NONE) && (tag == bus.tag);
    endfunction

endpackage

// File: rtl/rs_oldest_ready.sv
// Combinational priority picker: one-hot select of the lowest-index set ready bit.
// Lowest index is the oldest entry in the collapsing queue.
module rs_oldest_ready #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] sel_o,
    output logic             found_o
);

    always_comb begin
        sel_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && !found_o) begin
                sel_o[i] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_integer.sv
// Integer reservation station: collapsing queue of ops waiting on operand tags,
// snoops the CDB and issues the oldest ready op to the execution unit each cycle.
module rs_integer
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [INST_W-1:0]      dispatch_inst,
    input  logic [TAG_W-1:0]       dispatch_dest,
    input  logic [TAG_W-1:0]       dispatch_tag1,
    input  logic [XLEN-1:0]        dispatch_val1,
    input  logic [TAG_W-1:0]       dispatch_tag2,
    input  logic [XLEN-1:0]        dispatch_val2,
    input  logic [TAG_W+XLEN-1:0]  cdb,
    output logic                   exe_en,
    output logic [79:0]            rs2exe,
    output logic [CNT_W-1:0]       count
);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_ent;
    logic [CNT_W-1:0] count_q, count_d, wr_idx;
    logic             exe_en_q, exe_en_d;
    rs2exe_t          rs2exe_q, rs2exe_d;
    cdb_t             cdb_w;
    logic [DEPTH-1:0] ready, sel;
    logic             found, issue, accept, past_k;

    assign cdb_w          = cdb;
    assign dispatch_ready = count_q < CNT_W'(DEPTH);
    assign issue          = found && !flush;
    assign accept         = dispatch_valid && dispatch_ready && !flush;
    assign wr_idx         = count_q - CNT_W'(issue);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CNT_W'(i) < count_q) && (ent_q[i].tag1 == TAG_NONE)
                       && (ent_q[i].tag2 == TAG_NONE);
        end
    end

    rs_oldest_ready #(.DEPTH(DEPTH)) u_pick (
        .ready_i (ready),
        .sel_o   (sel),
        .found_o (found)
    );

    // Incoming op with same-cycle CDB bypass on each operand.
    always_comb begin
        new_ent.inst = dispatch_inst;
        new_ent.dest = dispatch_dest;
        new_ent.tag1 = cdb_hit(dispatch_tag1, cdb_w) ? TAG_NONE    : dispatch_tag1;
        new_ent.val1 = cdb_hit(dispatch_tag1, cdb_w) ? cdb_w.value : dispatch_val1;
        new_ent.tag2 = cdb_hit(dispatch_tag2, cdb_w) ? TAG_NONE    : dispatch_tag2;
        new_ent.val2 = cdb_hit(dispatch_tag2, cdb_w) ? cdb_w.value : dispatch_val2;
    end

    always_comb begin
        rs2exe_d = '0;
        exe_en_d = issue;
        if (issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel[i]) begin
                    rs2exe_d = {ent_q[i].inst, ent_q[i].dest, ent_q[i].val1, ent_q[i].val2};
                end
            end
        end

        // Collapse over the issued slot, then snoop, then append at the new tail.
        past_k = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            past_k   = past_k | (issue & sel[i]);
            ent_d[i] = past_k ? ent_q[i+1] : ent_q[i];
        end
        ent_d[DEPTH-1] = ent_q[DEPTH-1];

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit(ent_d[i].tag1, cdb_w)) begin
                ent_d[i].tag1 = TAG_NONE;
                ent_d[i].val1 = cdb_w.value;
            end
            if (cdb_hit(ent_d[i].tag2, cdb_w)) begin
                ent_d[i].tag2 = TAG_NONE;
                ent_d[i].val2 = cdb_w.value;
            end
            if (accept && (CNT_W'(i) == wr_idx)) begin
                ent_d[i] = new_ent;
            end
        end

        count_d = flush ? '0 : (count_q - CNT_W'(issue) + CNT_W'(accept));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            exe_en_q <= 1'b0;
            rs2exe_q <= '0;
        end else begin
            count_q  <= count_d;
            exe_en_q <= exe_en_d;
            rs2exe_q <= rs2exe_d;
        end
    end

    // Payload storage needs no reset: validity comes from count_q alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && dispatch_valid) begin
            assert (dispatch_ready);
            assert (dispatch_dest != TAG_NONE);
        end
    end

    assign count  = count_q;
    assign exe_en = exe_en_q;
    assign rs2exe = rs2exe_q;

endmodule

// File: tb/tb_rs_integer.sv
// Directed bench for rs_integer: dispatch, CDB wakeup, bypass, oldest-first issue,
// collapse with concurrent dispatch, flush and mid-stream reset.
module tb_rs_integer;

    logic        clk = 1'b0;
    logic        rst_n, flush, dispatch_valid, dispatch_ready;
    logic [9:0]  dispatch_inst;
    logic [5:0]  dispatch_dest, dispatch_tag1, dispatch_tag2;
    logic [31:0] dispatch_val1, dispatch_val2;
    logic [37:0] cdb;
    logic        exe_en;
    logic [79:0] rs2exe;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    rs_integer #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_inst  (dispatch_inst),
        .dispatch_dest  (dispatch_dest),
        .dispatch_tag1  (dispatch_tag1),
        .dispatch_val1  (dispatch_val1),
        .dispatch_tag2  (dispatch_tag2),
        .dispatch_val2  (dispatch_val2),
        .cdb            (cdb),
        .exe_en         (exe_en),
        .rs2exe         (rs2exe),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] word(input logic [9:0] inst, input logic [5:0] dest,
                                         input logic [31:0] o1, input logic [31:0] o2);
        return {inst, dest, o1, o2};
    endfunction

    task automatic disp(input logic [9:0] inst, input logic [5:0] dest,
                        input logic [5:0] t1, input logic [31:0] v1,
                        input logic [5:0] t2, input logic [31:0] v2);
        dispatch_valid = 1'b1;
        dispatch_inst  = inst;
        dispatch_dest  = dest;
        dispatch_tag1  = t1;
        dispatch_val1  = v1;
        dispatch_tag2  = t2;
        dispatch_val2  = v2;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb            = '0;
        flush          = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [79:0] w, input int cnt);
        chk({tag, "_en"}, {79'd0, exe_en}, {79'd0, en});
        chk({tag, "_word"}, rs2exe, w);
        chk({tag, "_count"}, {77'd0, count}, 80'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        disp(10'h0, 6'd1, 6'd0, 32'd0, 6'd0, 32'd0);
        dispatch_valid = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 80'd0, 0);
        chk("reset_ready", {79'd0, dispatch_ready}, 80'd1);
        rst_n = 1'b1;

        // Ready ADD: accepted at first edge, issued at second.
        disp(10'h000, 6'd5, 6'd0, 32'd3, 6'd0, 32'd4);
        tick();
        chk_out("add_disp", 1'b0, 80'd0, 1);
        idle();
        tick();
        chk_out("add_issue", 1'b1, word(10'h000, 6'd5, 32'd3, 32'd4), 0);
        tick();
        chk_out("add_drain", 1'b0, 80'd0, 0);

        // Wait on tag 9, woken by CDB, issues one cycle after capture.
        disp(10'h001, 6'd7, 6'd9, 32'd0, 6'd0, 32'd1);
        tick();
        idle();
        tick();
        chk_out("wait9", 1'b0, 80'd0, 1);
        cdb = {6'd9, 32'h10};
        tick();
        chk_out("cap9", 1'b0, 80'd0, 1);
        cdb = '0;
        tick();
        chk_out("wake9", 1'b1, word(10'h001, 6'd7, 32'h10, 32'd1), 0);

        // Both operands waiting on the same tag.
        disp(10'h00f, 6'd9, 6'd15, 32'd0, 6'd15, 32'd0);
        tick();
        idle();
        cdb = {6'd15, 32'h77};
        tick();
        cdb = '0;
        tick();
        chk_out("both15", 1'b1, word(10'h00f, 6'd9, 32'h77, 32'h77), 0);

        // Dispatch-cycle bypass on operand 2.
        disp(10'h002, 6'd8, 6'd0, 32'd2, 6'd12, 32'd0);
        cdb = {6'd12, 32'hABCD};
        tick();
        chk_out("byp_disp", 1'b0, 80'd0, 1);
        idle();
        tick();
        chk_out("byp_issue", 1'b1, word(10'h002, 6'd8, 32'd2, 32'hABCD), 0);

        // Fill on tag 20, then in-order drain.
        for (int i = 0; i < 4; i++) begin
            disp(10'h003, 6'(10 + i), 6'd20, 32'd0, 6'd0, 32'(100 + i));
            tick();
        end
        idle();
        chk_out("full", 1'b0, 80'd0, 4);
        chk("full_ready", {79'd0, dispatch_ready}, 80'd0);
        cdb = {6'd20, 32'd1};
        tick();
        chk_out("cap20", 1'b0, 80'd0, 4);
        cdb = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("drain", 1'b1, word(10'h003, 6'(10 + i), 32'd1, 32'(100 + i)), 3 - i);
        end

        // Waiting head, ready second entry, concurrent dispatch.
        disp(10'h004, 6'd20, 6'd30, 32'd0, 6'd0, 32'd5);
        tick();
        disp(10'h005, 6'd21, 6'd0, 32'd6, 6'd0, 32'd7);
        tick();
        chk_out("mix_fill", 1'b0, 80'd0, 2);
        disp(10'h006, 6'd22, 6'd0, 32'd8, 6'd0, 32'd9);
        tick();
        chk_out("mix_issueB", 1'b1, word(10'h005, 6'd21, 32'd6, 32'd7), 2);
        idle();
        tick();
        chk_out("mix_issueC", 1'b1, word(10'h006, 6'd22, 32'd8, 32'd9), 1);
        cdb = {6'd30, 32'h55};
        tick();
        chk_out("mix_cap", 1'b0, 80'd0, 1);
        cdb = '0;
        tick();
        chk_out("mix_issueA", 1'b1, word(10'h004, 6'd20, 32'h55, 32'd5), 0);

        // Flush with three waiting entries and a dispatch in the same cycle.
        for (int i = 0; i < 3; i++) begin
            disp(10'h007, 6'(30 + i), 6'd40, 32'd0, 6'd0, 32'd0);
            tick();
        end
        chk_out("pre_flush", 1'b0, 80'd0, 3);
        disp(10'h008, 6'd33, 6'd0, 32'd1, 6'd0, 32'd2);
        flush = 1'b1;
        tick();
        chk_out("flush", 1'b0, 80'd0, 0);
        idle();
        cdb = {6'd40, 32'h99};
        tick();
        chk_out("post_flush", 1'b0, 80'd0, 0);
        cdb = '0;
        tick();
        chk_out("post_flush2", 1'b0, 80'd0, 0);

        // Reset mid-stream drops the second op.
        disp(10'h009, 6'd41, 6'd0, 32'd11, 6'd0, 32'd12);
        tick();
        disp(10'h00a, 6'd42, 6'd0, 32'd13, 6'd0, 32'd14);
        tick();
        chk_out("pre_rst", 1'b1, word(10'h009, 6'd41, 32'd11, 32'd12), 1);
        idle();
        rst_n = 1'b0;
        tick();
        chk_out("mid_rst", 1'b0, 80'd0, 0);
        chk("mid_rst_ready", {79'd0, dispatch_ready}, 80'd1);
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 1'b0, 80'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
